mips_reg_dump: RTL and testbench

//   Downstream consumer of the single-cycle MIPS core's debug outputs (done, show, PC).
//   On a trigger it sweeps peek_addr across r0..r31 and captures show for each register.
//   It streams every register, then PC, out of one UART TX line (8N1) for board-level readback.

---
 rtl/mips_reg_dump_pkg.sv | 18 +
 rtl/mips_reg_dump_uart_tx_byte.sv | 68 ++++++
 rtl/mips_reg_dump.sv | 160 ++++++++++++++++
 tb/tb_mips_reg_dump.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_reg_dump_pkg.sv
// Shared constants for the MIPS register dump block: record header, UART frame size, FSM states.
package mips_reg_dump_pkg;

   // Header byte that marks the trailing PC record
   localparam logic [7:0] HDR_PC = 8'hFF;

   // Start + 8 data + stop
   localparam int unsigned UART_FRAME_BITS = 10;

   // Dump FSM state encodings
   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StSetup   = 3'd1;
   localparam logic [2:0] StCapture = 3'd2;
   localparam logic [2:0] StSend    = 3'd3;
   localparam logic [2:0] StNext    = 3'd4;
   localparam logic [2:0] StFin     = 3'd5;

endpackage

// File: rtl/mips_reg_dump_uart_tx_byte.sv
// 8N1 UART transmitter for one byte at a time with a valid/ready handshake.
module uart_tx_byte
   import mips_reg_dump_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx
);

   localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   logic              active_q, active_d;
   logic [9:0]        shift_q, shift_d;
   logic [3:0]        bit_cnt_q, bit_cnt_d;
   logic [BaudW-1:0]  baud_cnt_q, baud_cnt_d;

   // Load a byte when idle, then shift one frame bit out every CLKS_PER_BIT cycles
   always_comb begin
      active_d   = active_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      baud_cnt_d = baud_cnt_q;
      if (!active_q) begin
         if (tx_valid) begin
            active_d   = 1'b1;
            shift_d    = {1'b1, tx_data, 1'b0};
            bit_cnt_d  = '0;
            baud_cnt_d = '0;
         end
      end else if (baud_cnt_q == BaudW'(CLKS_PER_BIT - 1)) begin
         baud_cnt_d = '0;
         if (bit_cnt_q == 4'(UART_FRAME_BITS - 1)) begin
            // Last cycle of the stop bit: ready rises on the next cycle
            active_d  = 1'b0;
            bit_cnt_d = '0;
         end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            shift_d   = {1'b1, shift_q[9:1]};
         end
      end else begin
         baud_cnt_d = baud_cnt_q + BaudW'(1);
      end
   end

   // Transmitter state; reset aborts any byte in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         active_q   <= 1'b0;
         shift_q    <= '1;
         bit_cnt_q  <= '0;
         baud_cnt_q <= '0;
      end else begin
         active_q   <= active_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         baud_cnt_q <= baud_cnt_d;
      end
   end

   assign tx_ready = !active_q;
   assign tx       = active_q ? shift_q[0] : 1'b1;

endmodule

// File: rtl/mips_reg_dump.sv
// Sweeps the core's peek_addr over all registers, captures each value and streams
// register records followed by a PC record out of a UART.
module mips_reg_dump
   import mips_reg_dump_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned SETTLE       = 2,
   parameter int unsigned NUM_REGS     = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        done,
   input  logic [31:0] show,
   input  logic [31:0] PC,
   output logic [4:0]  peek_addr,
   output logic        tx,
   output logic        busy,
   output logic        frame_done
);

   logic [2:0]  state_q, state_d;
   logic [5:0]  idx_q, idx_d;
   logic [7:0]  settle_q, settle_d;
   logic [2:0]  byte_cnt_q, byte_cnt_d;
   logic [31:0] word_q, word_d;
   logic [4:0]  peek_q, peek_d;
   logic        busy_q, busy_d;
   logic        done_q;
   logic        trigger, is_pc;
   logic        tx_valid, tx_ready;
   logic [7:0]  tx_data;
   logic [7:0]  header;

   // A simultaneous start and done edge collapse into one trigger
   assign trigger = start | (done & ~done_q);
   assign is_pc   = (idx_q == 6'(NUM_REGS));
   assign header  = is_pc ? HDR_PC : {3'b000, idx_q[4:0]};
   assign tx_valid = (state_q == StSend);

   // Select the record byte currently offered to the UART
   always_comb begin
      tx_data = header;
      unique case (byte_cnt_q)
         3'd0:    tx_data = header;
         3'd1:    tx_data = word_q[31:24];
         3'd2:    tx_data = word_q[23:16];
         3'd3:    tx_data = word_q[15:8];
         3'd4:    tx_data = word_q[7:0];
         default: tx_data = header;
      endcase
   end

   // Dump sequencing: settle, capture, send five bytes, advance
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      settle_d   = settle_q;
      byte_cnt_d = byte_cnt_q;
      word_d     = word_q;
      peek_d     = peek_q;
      busy_d     = busy_q;
      unique case (state_q)
         StIdle: begin
            if (trigger) begin
               busy_d   = 1'b1;
               idx_d    = '0;
               peek_d   = '0;
               settle_d = '0;
               state_d  = StSetup;
            end
         end
         StSetup: begin
            if (settle_q == 8'(SETTLE - 1)) begin
               settle_d = '0;
               state_d  = StCapture;
            end else begin
               settle_d = settle_q + 8'd1;
            end
         end
         StCapture: begin
            word_d     = is_pc ? PC : show;
            byte_cnt_d = '0;
            state_d    = StSend;
         end
         StSend: begin
            if (tx_ready) begin
               if (byte_cnt_q == 3'd4) begin
                  byte_cnt_d = '0;
                  state_d    = StNext;
               end else begin
                  byte_cnt_d = byte_cnt_q + 3'd1;
               end
            end
         end
         StNext: begin
            if (is_pc) begin
               // Hold until the final stop bit has fully left the line
               if (tx_ready) begin
                  busy_d  = 1'b0;
                  state_d = StFin;
               end
            end else begin
               idx_d = idx_q + 6'd1;
               if (idx_q + 6'd1 == 6'(NUM_REGS)) begin
                  state_d = StCapture;
               end else begin
                  peek_d  = 5'(idx_q + 6'd1);
                  state_d = StSetup;
               end
            end
         end
         StFin: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // FSM, counters, capture register and edge detector
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         settle_q   <= '0;
         byte_cnt_q <= '0;
         word_q     <= '0;
         peek_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         settle_q   <= settle_d;
         byte_cnt_q <= byte_cnt_d;
         word_q     <= word_d;
         peek_q     <= peek_d;
         busy_q     <= busy_d;
         done_q     <= done;
      end
   end

   assign peek_addr  = peek_q;
   assign busy       = busy_q;
   assign frame_done = (state_q == StFin);

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_uart (
      .clk     (clk),
      .reset   (reset),
      .tx_valid(tx_valid),
      .tx_data (tx_data),
      .tx_ready(tx_ready),
      .tx      (tx)
   );

endmodule

// File: tb/tb_mips_reg_dump.sv
// Bench for mips_reg_dump: UART RX model, frame model and directed trigger/reset sequences.
module tb_mips_reg_dump;

   localparam int CPB      = 4;
   localparam int NBYTES   = 165;
   localparam logic [31:0] PC_VAL = 32'h0040_0020;

   logic        clk = 1'b0;
   logic        reset;
   logic        start = 1'b0;
   logic        done = 1'b0;
   logic [31:0] show;
   logic [31:0] pc = PC_VAL;
   logic [4:0]  peek_addr;
   logic        tx, busy, frame_done;

   int tests = 0;
   int failed = 0;

   always #5 clk = ~clk;

   mips_reg_dump #(
      .CLKS_PER_BIT(CPB),
      .SETTLE      (2),
      .NUM_REGS    (32)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .done      (done),
      .show      (show),
      .PC        (pc),
      .peek_addr (peek_addr),
      .tx        (tx),
      .busy      (busy),
      .frame_done(frame_done)
   );

   // Core model: show follows peek_addr; in freeze mode it toggles once the capture window is over
   logic garble = 1'b0;
   int   since_chg = 0;
   logic tog = 1'b0;
   logic [4:0] prev_pa = '0;
   logic prev_busy = 1'b0;

   always_comb begin
      show = 32'hA500_0000 | {27'd0, peek_addr};
      if (garble && since_chg > 2) show = tog ? 32'hFFFF_FFFF : 32'h1234_5678;
   end

   // Monitors and UART receiver, all sampled on the falling edge
   int   cyc = 0;
   int   fd_cnt = 0;
   int   tx_edges = 0;
   int   rx_err = 0;
   logic prev_tx = 1'b1;
   logic rx_active = 1'b0;
   int   rx_cnt = 0;
   logic rx_bit = 1'b0;
   logic [7:0] rx_sh = '0;
   logic [7:0] rx_bytes[$];
   int   rx_start[$];

   always @(negedge clk) begin
      cyc = cyc + 1;
      tog = ~tog;
      if (peek_addr != prev_pa || (busy && !prev_busy)) since_chg = 0;
      else since_chg = since_chg + 1;
      prev_pa = peek_addr;
      prev_busy = busy;
      if (frame_done) fd_cnt = fd_cnt + 1;
      if (tx != prev_tx) tx_edges = tx_edges + 1;
      prev_tx = tx;
      if (!reset) begin
         rx_active = 1'b0;
      end else if (!rx_active) begin
         if (tx == 1'b0) begin
            rx_active = 1'b1;
            rx_cnt = 0;
            rx_bit = 1'b0;
            rx_start.push_back(cyc);
         end
      end else begin
         rx_cnt = rx_cnt + 1;
         if (rx_cnt % CPB == 0) begin
            rx_bit = tx;
            if (rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8) rx_sh = {tx, rx_sh[7:1]};
            if (rx_cnt / CPB == 9 && tx != 1'b1) rx_err = rx_err + 1;
         end else if (tx != rx_bit) begin
            rx_err = rx_err + 1;
         end
         if (rx_cnt == 10 * CPB - 1) begin
            rx_bytes.push_back(rx_sh);
            rx_active = 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference frame: registers carry A5000000|idx, the PC record carries PC_VAL
   function automatic logic [7:0] model_byte(input int n);
      int rec;
      int b;
      logic [31:0] w;
      logic [7:0] h;
      rec = n / 5;
      b = n % 5;
      if (rec < 32) begin
         h = 8'(rec);
         w = 32'hA500_0000 | 32'(rec);
      end else begin
         h = 8'hFF;
         w = PC_VAL;
      end
      case (b)
         0: return h;
         1: return w[31:24];
         2: return w[23:16];
         3: return w[15:8];
         default: return w[7:0];
      endcase
   endfunction

   typedef struct {
      int          rec;
      logic [7:0]  hdr;
      logic [31:0] word;
   } rec_vec_t;

   rec_vec_t vecs[6];

   task automatic check_table(input string tag, input int base);
      logic [7:0] exp_b[5];
      logic [7:0] act;
      int k;
      for (int v = 0; v < 6; v++) begin
         exp_b[0] = vecs[v].hdr;
         exp_b[1] = vecs[v].word[31:24];
         exp_b[2] = vecs[v].word[23:16];
         exp_b[3] = vecs[v].word[15:8];
         exp_b[4] = vecs[v].word[7:0];
         for (int b = 0; b < 5; b++) begin
            k = base + vecs[v].rec * 5 + b;
            act = (k < rx_bytes.size()) ? rx_bytes[k] : 8'hxx;
            check($sformatf("%s_rec%0d_b%0d", tag, vecs[v].rec, b), act, exp_b[b]);
         end
      end
   endtask

   task automatic check_frame(input string tag, input int base);
      int bad;
      logic [7:0] act;
      check({tag, "_count"}, rx_bytes.size() - base, NBYTES);
      bad = 0;
      for (int i = 0; i < NBYTES; i++) begin
         act = (base + i < rx_bytes.size()) ? rx_bytes[base + i] : 8'hxx;
         if (act !== model_byte(i)) begin
            bad++;
            if (bad <= 4) $display("FAIL %s_byte%0d: got %0h, expected %0h", tag, i, act,
                                   model_byte(i));
         end
      end
      check({tag, "_bytes_bad"}, bad, 0);
   endtask

   task automatic wait_frames(input int fd_base, input int n, input int budget, input string name);
      int c = 0;
      while (fd_cnt - fd_base < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      check({name, "_frame_done_seen"}, (fd_cnt - fd_base >= n), 1'b1);
      repeat (50) @(negedge clk);
   endtask

   task automatic wait_bytes(input int base, input int n, input int budget, input string name);
      int c = 0;
      while (rx_bytes.size() - base < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      check({name, "_bytes_reached"}, (rx_bytes.size() - base >= n), 1'b1);
   endtask

   task automatic pulse_start(input string name);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({name, "_busy_rise"}, busy, 1'b1);
   endtask

   initial begin
      #(950000);
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int b0, f0, e0, bad;
      vecs[0] = '{0,  8'h00, 32'hA500_0000};
      vecs[1] = '{1,  8'h01, 32'hA500_0001};
      vecs[2] = '{2,  8'h02, 32'hA500_0002};
      vecs[3] = '{16, 8'h10, 32'hA500_0010};
      vecs[4] = '{31, 8'h1F, 32'hA500_001F};
      vecs[5] = '{32, 8'hFF, 32'h0040_0020};

      // 1: reset holds everything idle
      reset = 1'b0;
      #1;
      check("rst_tx", tx, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_peek", peek_addr, 5'd0);
      check("rst_frame_done", frame_done, 1'b0);
      e0 = tx_edges;
      repeat (1000) @(negedge clk);
      check("rst_no_tx_edges", tx_edges - e0, 0);
      check("rst_busy_hold", busy, 1'b0);
      #2 reset = 1'b1;
      repeat (20) @(negedge clk);
      check("idle_busy", busy, 1'b0);
      check("idle_tx", tx, 1'b1);

      // 2/3: full frame, contents and bit timing
      b0 = rx_bytes.size(); f0 = fd_cnt; e0 = rx_err;
      pulse_start("full");
      wait_frames(f0, 1, 20000, "full");
      check_frame("full", b0);
      check_table("full", b0);
      check("full_one_frame_done", fd_cnt - f0, 1);
      check("full_busy_end", busy, 1'b0);
      check("full_peek_hold", peek_addr, 5'd31);
      check("timing_bit_errs", rx_err - e0, 0);
      bad = 0;
      for (int i = 1; i < NBYTES && b0 + i < rx_start.size(); i++)
         if (rx_start[b0 + i] - rx_start[b0 + i - 1] != 10 * CPB + 1) bad++;
      check("timing_byte_period", bad, 0);
      if (b0 + NBYTES - 1 < rx_start.size())
         check("timing_frame_len",
               (rx_start[b0 + NBYTES - 1] + 10 * CPB - rx_start[b0] <= NBYTES * 41), 1'b1);

      // 4a: done held high produces one frame
      b0 = rx_bytes.size(); f0 = fd_cnt;
      @(negedge clk);
      done = 1'b1;
      repeat (10000) @(negedge clk);
      done = 1'b0;
      wait_frames(f0, 1, 2000, "done_hold");
      check("done_hold_frames", fd_cnt - f0, 1);
      check_frame("done_hold", b0);

      // 4b: start while busy is ignored
      b0 = rx_bytes.size(); f0 = fd_cnt;
      pulse_start("ignore");
      wait_bytes(b0, 20, 5000, "ignore");
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_frames(f0, 1, 20000, "ignore");
      repeat (200) @(negedge clk);
      check("ignore_frames", fd_cnt - f0, 1);
      check_frame("ignore", b0);

      // 4c: start and done rising together
      b0 = rx_bytes.size(); f0 = fd_cnt;
      @(negedge clk);
      start = 1'b1;
      done = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_frames(f0, 1, 20000, "both");
      done = 1'b0;
      repeat (200) @(negedge clk);
      check("both_frames", fd_cnt - f0, 1);
      check("both_bytes", rx_bytes.size() - b0, NBYTES);

      // 5: asynchronous reset in the middle of byte 50
      b0 = rx_bytes.size();
      pulse_start("midrst");
      wait_bytes(b0, 50, 5000, "midrst");
      repeat (10) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("midrst_tx", tx, 1'b1);
      check("midrst_busy", busy, 1'b0);
      check("midrst_peek", peek_addr, 5'd0);
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      repeat (5) @(negedge clk);
      b0 = rx_bytes.size(); f0 = fd_cnt;
      pulse_start("after_rst");
      wait_frames(f0, 1, 20000, "after_rst");
      check("after_rst_first_hdr", (b0 < rx_bytes.size()) ? rx_bytes[b0] : 8'hxx, 8'h00);
      check_frame("after_rst", b0);

      // 6: show toggles after capture; captured words stay intact
      garble = 1'b1;
      b0 = rx_bytes.size(); f0 = fd_cnt;
      pulse_start("freeze");
      wait_frames(f0, 1, 20000, "freeze");
      garble = 1'b0;
      check_frame("freeze", b0);
      check_table("freeze", b0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
